load_store_aligner: RTL and testbench
=====================================

LOAD_STORE_ALIGNER -- requirements
Module: load_store_aligner

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning memory data width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter ALLOW_MISALIGNED, default 1, meaning 1 splits line-crossing accesses into two beats and 0 flags them as errors.
REQ-003 SHALL have port clk  in  1  clock; the block has one clock, and all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; reset is asynchronous and active-low.
REQ-005 SHALL have port ReqValid  in  1  CPU access request.
REQ-006 SHALL have port ReqReady  out  1  request accepted this cycle when high together with ReqValid.
REQ-007 SHALL have port ReqWrite  in  1  1 means store, 0 means load.
REQ-008 SHALL have port Address  in  32  byte address.
REQ-009 SHALL have port DataType  in  2  access size: 00 byte, 01 half, 10 word, 11 dword; 11 is treated as word when DATA_W=32.
REQ-010 SHALL have port Unsigned  in  1  load zero-extends when 1 and sign-extends when 0.
REQ-011 SHALL have port WriteData  in  DATA_W  store data, right-justified.
REQ-012 SHALL have port MemValid  out  1  memory beat request.
REQ-013 SHALL have port MemReady  in  1  beat completes when MemValid&&MemReady; MemRData is valid in that same cycle.
REQ-014 SHALL have port MemAddr  out  32  beat address, aligned to DATA_W/8.
REQ-015 SHALL have port MemWrite  out  1  beat is a store.
REQ-016 SHALL have port ByteEnable  out  DATA_W/8  per-byte lane enables.
REQ-017 SHALL have port MemWData  out  DATA_W  lane-shifted store data.
REQ-018 SHALL have port MemRData  in  DATA_W  raw line read data.
REQ-019 SHALL have port RespValid  out  1  one-cycle completion pulse.
REQ-020 SHALL have port ReadData  out  DATA_W  aligned, extended load result.
REQ-021 SHALL have port Error  out  1  misaligned access rejected; valid with RespValid.

Function
REQ-022 SHALL use a state machine with states IDLE, BEAT0, BEAT1 and RESP.
REQ-023 SHALL drive ReqReady=1 only in IDLE; on ReqValid&&ReqReady it SHALL register all request fields and go to BEAT0.
REQ-024 SHALL compute, with B=DATA_W/8, off=Address mod B and n=1<<DataType: mask2 = ((1<<n)-1)<<off over 2B bits; split = |mask2[2B-1:B].
REQ-025 SHALL, when split and ALLOW_MISALIGNED=0, take IDLE->RESP directly: no memory beat, Error=1, ReadData=0.
REQ-026 SHALL, in BEAT0, drive MemValid=1, MemAddr=Address&~(B-1), ByteEnable=mask2[B-1:0], and MemWData equal to the low B bytes of ({DATA_W zeros, WriteData}<<(8*off)).
REQ-027 SHALL, in BEAT1, drive MemAddr+B, ByteEnable=mask2[2B-1:B], and the high half of the same shifted store data.
REQ-028 SHALL hold MemValid and all beat fields stable until MemReady; a stalled beat SHALL NOT change state.
REQ-029 SHALL, on BEAT0 completion, go to BEAT1 if split, else to RESP; BEAT1 completion SHALL go to RESP.
REQ-030 SHALL, for loads, capture MemRData at each beat completion and assemble ReadData = ({beat1,beat0}>>(8*off)) truncated to n bytes, then zero- or sign-extended to DATA_W per Unsigned.
REQ-031 SHALL drive ReadData=0 for stores.
REQ-032 SHALL assert RespValid for exactly one cycle in RESP, then return to IDLE; ReadData and Error SHALL hold until the next RespValid.
REQ-033 SHALL NOT accept a new request in the same cycle as RespValid; minimum latency is accept +2 cycles for aligned accesses and +3 cycles for split accesses, with zero-wait memory.
REQ-034 SHALL treat Address as wrapping modulo 2^32 for the BEAT1 address.
REQ-035 SHALL drive MemValid=0, ByteEnable=0 and MemWrite=0 whenever not in BEAT0 or BEAT1.

Reset
REQ-036 SHALL, while rst_n=0, force state IDLE and all outputs to 0 except ReqReady, regardless of clk.
REQ-037 SHALL, when rst_n is asserted mid-access, abandon the access with no response pulse; ReqReady=1 on the first clock after release.

Verification
REQ-038 SHALL pass, with DATA_W=32: store byte at Address 0x103, WriteData 0xAB -> one beat, MemAddr 0x100, ByteEnable 0b1000, MemWData 0xAB000000.
REQ-039 SHALL pass, with DATA_W=32: load half at 0x102, Unsigned=0, MemRData 0x8001_xxxx -> ReadData 0xFFFF8001, RespValid 2 cycles after accept.
REQ-040 SHALL pass, with DATA_W=32 and ALLOW_MISALIGNED=1: store word at 0x1FE, data 0x11223344 -> beat 0x1FC with ByteEnable 1100 and data 0x33440000, then beat 0x200 with ByteEnable 0011 and data 0x00001122.
REQ-041 SHALL pass, with ALLOW_MISALIGNED=0: word load at 0x001 -> no MemValid, RespValid and Error=1 one cycle after accept.
REQ-042 SHALL pass: MemReady held low for 5 cycles in BEAT0 -> MemValid and all beat fields stable throughout, RespValid exactly once.
REQ-043 SHALL pass: rst_n pulsed low during BEAT1 -> outputs 0 immediately, no RespValid, and a new request is accepted after release.

Source files
------------

// File: rtl/load_store_aligner_if.sv
// CPU request and memory beat signals of the load/store aligner.
// The slave side is the aligner; the master side is the CPU and memory model.
interface load_store_aligner_if #(
   parameter int DATA_W = 32
);
   logic                  ReqValid;
   logic                  ReqReady;
   logic                  ReqWrite;
   logic [31:0]           Address;
   logic [1:0]            DataType;
   logic                  Unsigned;
   logic [DATA_W-1:0]     WriteData;
   logic                  MemValid;
   logic                  MemReady;
   logic [31:0]           MemAddr;
   logic                  MemWrite;
   logic [DATA_W/8-1:0]   ByteEnable;
   logic [DATA_W-1:0]     MemWData;
   logic [DATA_W-1:0]     MemRData;
   logic                  RespValid;
   logic [DATA_W-1:0]     ReadData;
   logic                  Error;

   modport slave (
      input  ReqValid, ReqWrite, Address, DataType, Unsigned, WriteData,
      input  MemReady, MemRData,
      output ReqReady, MemValid, MemAddr, MemWrite, ByteEnable, MemWData,
      output RespValid, ReadData, Error
   );

   modport master (
      output ReqValid, ReqWrite, Address, DataType, Unsigned, WriteData,
      output MemReady, MemRData,
      input  ReqReady, MemValid, MemAddr, MemWrite, ByteEnable, MemWData,
      input  RespValid, ReadData, Error
   );
endinterface

// File: rtl/load_store_aligner.sv
// Turns byte/half/word/dword CPU accesses into lane-aligned memory beats,
// splitting line-crossing accesses into two beats or rejecting them.
module load_store_aligner #(
   parameter int DATA_W           = 32,
   parameter int ALLOW_MISALIGNED = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   load_store_aligner_if.slave bus
);
   localparam int B    = DATA_W / 8;
   localparam int OFFW = $clog2(B);
   localparam int LW   = 2 * DATA_W;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   state_t              state_q;
   logic [31:0]         lineAddr_q;
   logic [OFFW-1:0]     off_q;
   logic [1:0]          size_q;
   logic                unsExt_q;
   logic                write_q;
   logic                split_q;
   logic [2*B-1:0]      mask_q;
   logic [LW-1:0]       wdata_q;
   logic [DATA_W-1:0]   beat0Data_q;
   logic [DATA_W-1:0]   readData_q;
   logic                error_q;

   logic [1:0]          reqSize;
   logic [OFFW-1:0]     reqOff;
   logic [2*B-1:0]      reqMask;
   logic                reqSplit;
   logic [LW-1:0]       reqWide;
   logic [LW-1:0]       lineData;
   logic [DATA_W-1:0]   loadResult;
   logic                inBeat;
   logic                beatDone;

   // A dword request on a 32-bit bus degrades to a word access.
   function automatic logic [1:0] effSize(input logic [1:0] dt);
      if (DATA_W == 32 && dt == 2'b11) return 2'b10;
      return dt;
   endfunction

   function automatic logic [2*B-1:0] laneMask(input logic [1:0] sz, input logic [OFFW-1:0] off);
      logic [2*B-1:0] m;
      int nb;
      nb = 1 << sz;
      m  = '0;
      for (int i = 0; i < 2*B; i++) begin
         if (i >= int'(off) && i < int'(off) + nb) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] alignLoad(input logic [LW-1:0] line, input logic [OFFW-1:0] off,
                                                   input logic [1:0] sz, input logic uns);
      logic [LW-1:0]     sh;
      logic [DATA_W-1:0] r;
      logic              sign;
      int                nbits;
      sh    = line >> {off, 3'b000};
      nbits = 8 << sz;
      sign  = sh[nbits-1];
      for (int i = 0; i < DATA_W; i++) begin
         r[i] = (i < nbits) ? sh[i] : (uns ? 1'b0 : sign);
      end
      return r;
   endfunction

   // Request decode happens on the live inputs so the IDLE decision is immediate.
   always_comb begin
      reqSize  = effSize(bus.DataType);
      reqOff   = bus.Address[OFFW-1:0];
      reqMask  = laneMask(reqSize, reqOff);
      reqSplit = |reqMask[2*B-1:B];
      reqWide  = {{DATA_W{1'b0}}, bus.WriteData} << {reqOff, 3'b000};
   end

   // The second beat's data sits above the first when assembling a split load.
   always_comb begin
      lineData = {{DATA_W{1'b0}}, bus.MemRData};
      if (state_q == BEAT1) lineData = {bus.MemRData, beat0Data_q};
      loadResult = write_q ? '0 : alignLoad(lineData, off_q, size_q, unsExt_q);
   end

   assign inBeat   = (state_q == BEAT0) || (state_q == BEAT1);
   assign beatDone = inBeat && bus.MemReady;

   assign bus.ReqReady   = (state_q == IDLE);
   assign bus.MemValid   = inBeat;
   assign bus.MemWrite   = inBeat && write_q;
   assign bus.MemAddr    = (state_q == BEAT0) ? lineAddr_q :
                           (state_q == BEAT1) ? lineAddr_q + 32'(B) : 32'h0;
   assign bus.ByteEnable = (state_q == BEAT0) ? mask_q[B-1:0] :
                           (state_q == BEAT1) ? mask_q[2*B-1:B] : '0;
   assign bus.MemWData   = (state_q == BEAT0) ? wdata_q[DATA_W-1:0] :
                           (state_q == BEAT1) ? wdata_q[LW-1:DATA_W] : '0;
   assign bus.RespValid  = (state_q == RESP);
   assign bus.ReadData   = readData_q;
   assign bus.Error      = error_q;

   // Request fields are captured once at accept and stay put for both beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lineAddr_q  <= '0;
         off_q       <= '0;
         size_q      <= '0;
         unsExt_q    <= 1'b0;
         write_q     <= 1'b0;
         split_q     <= 1'b0;
         mask_q      <= '0;
         wdata_q     <= '0;
         beat0Data_q <= '0;
         readData_q  <= '0;
         error_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.ReqValid) begin
                  lineAddr_q <= {bus.Address[31:OFFW], {OFFW{1'b0}}};
                  off_q      <= reqOff;
                  size_q     <= reqSize;
                  unsExt_q   <= bus.Unsigned;
                  write_q    <= bus.ReqWrite;
                  split_q    <= reqSplit;
                  mask_q     <= reqMask;
                  wdata_q    <= reqWide;
                  if (reqSplit && ALLOW_MISALIGNED == 0) begin
                     readData_q <= '0;
                     error_q    <= 1'b1;
                     state_q    <= RESP;
                  end else begin
                     state_q    <= BEAT0;
                  end
               end
            end
            BEAT0: begin
               if (beatDone) begin
                  beat0Data_q <= bus.MemRData;
                  if (split_q) begin
                     state_q <= BEAT1;
                  end else begin
                     readData_q <= loadResult;
                     error_q    <= 1'b0;
                     state_q    <= RESP;
                  end
               end
            end
            BEAT1: begin
               if (beatDone) begin
                  readData_q <= loadResult;
                  error_q    <= 1'b0;
                  state_q    <= RESP;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_aligner.sv
// Directed bench: dutA splits misaligned accesses, dutB rejects them.
module tb_load_store_aligner;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checkCount = 0;
   int   errorCount = 0;
   int   respCountA = 0;
   int   memBeatsB  = 0;

   always #5 clk = ~clk;

   load_store_aligner_if #(.DATA_W(32)) ifA ();
   load_store_aligner_if #(.DATA_W(32)) ifB ();

   load_store_aligner #(.DATA_W(32), .ALLOW_MISALIGNED(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
   load_store_aligner #(.DATA_W(32), .ALLOW_MISALIGNED(0)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

   always @(posedge clk) begin
      if (ifA.RespValid === 1'b1) respCountA++;
      if (ifB.MemValid === 1'b1) memBeatsB++;
   end

   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] dt,
                                input logic uns, input logic [31:0] wdata);
      ifA.ReqValid  = 1'b1;
      ifA.ReqWrite  = wr;
      ifA.Address   = addr;
      ifA.DataType  = dt;
      ifA.Unsigned  = uns;
      ifA.WriteData = wdata;
   endtask

   task automatic test_reset();
      #12;
      checkCount++;
      if (ifA.ReqReady !== 1'b1 || ifA.MemValid !== 1'b0 || ifA.ByteEnable !== 4'h0 || ifA.MemWrite !== 1'b0 ||
          ifA.MemAddr !== 32'h0 || ifA.MemWData !== 32'h0 || ifA.RespValid !== 1'b0 || ifA.ReadData !== 32'h0 ||
          ifA.Error !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL reset_A: got rdy=%b mv=%b be=%b mw=%b ma=%h wd=%h rv=%b rd=%h err=%b expected rdy=1 rest 0",
                  ifA.ReqReady, ifA.MemValid, ifA.ByteEnable, ifA.MemWrite, ifA.MemAddr, ifA.MemWData,
                  ifA.RespValid, ifA.ReadData, ifA.Error);
      end
      checkCount++;
      if (ifB.ReqReady !== 1'b1 || ifB.MemValid !== 1'b0 || ifB.RespValid !== 1'b0 || ifB.Error !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL reset_B: got rdy=%b mv=%b rv=%b err=%b expected 1 0 0 0",
                  ifB.ReqReady, ifB.MemValid, ifB.RespValid, ifB.Error);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkCount++;
      if (ifA.ReqReady !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL ready_after_reset: got %b expected 1", ifA.ReqReady);
      end
   endtask

   task automatic test_store_byte();
      @(negedge clk);
      applyStimulus(1'b1, 32'h103, 2'b00, 1'b0, 32'hAB);
      @(negedge clk);
      ifA.ReqValid = 1'b0;
      checkCount++;
      if (ifA.MemValid !== 1'b1 || ifA.MemWrite !== 1'b1 || ifA.MemAddr !== 32'h100 ||
          ifA.ByteEnable !== 4'b1000 || ifA.MemWData !== 32'hAB000000) begin
         errorCount++;
         $display("[TB] FAIL store_byte_beat: got mv=%b mw=%b ma=%h be=%b wd=%h expected 1 1 00000100 1000 ab000000",
                  ifA.MemValid, ifA.MemWrite, ifA.MemAddr, ifA.ByteEnable, ifA.MemWData);
      end
      @(negedge clk);
      checkCount++;
      if (ifA.RespValid !== 1'b1 || ifA.ReadData !== 32'h0 || ifA.Error !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL store_byte_resp: got rv=%b rd=%h err=%b expected 1 0 0",
                  ifA.RespValid, ifA.ReadData, ifA.Error);
      end
      @(negedge clk);
      checkCount++;
      if (ifA.RespValid !== 1'b0 || ifA.ReqReady !== 1'b1 || ifA.MemValid !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL store_byte_idle: got rv=%b rdy=%b mv=%b expected 0 1 0",
                  ifA.RespValid, ifA.ReqReady, ifA.MemValid);
      end
   endtask

   task automatic test_load_half();
      @(negedge clk);
      applyStimulus(1'b0, 32'h102, 2'b01, 1'b0, 32'h0);
      @(negedge clk);
      ifA.ReqValid = 1'b0;
      ifA.MemRData = 32'h80011234;
      checkCount++;
      if (ifA.MemValid !== 1'b1 || ifA.MemWrite !== 1'b0 || ifA.MemAddr !== 32'h100 ||
          ifA.ByteEnable !== 4'b1100 || ifA.RespValid !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL load_half_beat: got mv=%b mw=%b ma=%h be=%b rv=%b expected 1 0 00000100 1100 0",
                  ifA.MemValid, ifA.MemWrite, ifA.MemAddr, ifA.ByteEnable, ifA.RespValid);
      end
      @(negedge clk);
      checkCount++;
      if (ifA.RespValid !== 1'b1 || ifA.ReadData !== 32'hFFFF8001) begin
         errorCount++;
         $display("[TB] FAIL load_half_resp: got rv=%b rd=%h expected 1 ffff8001", ifA.RespValid, ifA.ReadData);
      end
      @(negedge clk);
      checkCount++;
      if (ifA.RespValid !== 1'b0 || ifA.ReadData !== 32'hFFFF8001) begin
         errorCount++;
         $display("[TB] FAIL load_half_hold: got rv=%b rd=%h expected 0 ffff8001", ifA.RespValid, ifA.ReadData);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  dt;
      logic        uns;
      logic [31:0] rdata;
      logic [31:0] expAddr;
      logic [3:0]  expBe;
      logic [31:0] expData;
   } loadVec_t;

   task automatic test_load_extend();
      loadVec_t vecs[5];
      vecs[0] = '{32'h101, 2'b00, 1'b1, 32'h12345678, 32'h100, 4'b0010, 32'h00000056};
      vecs[1] = '{32'h101, 2'b00, 1'b0, 32'h00009A00, 32'h100, 4'b0010, 32'hFFFFFF9A};
      vecs[2] = '{32'h102, 2'b01, 1'b1, 32'h80011234, 32'h100, 4'b1100, 32'h00008001};
      vecs[3] = '{32'h200, 2'b11, 1'b0, 32'hDEADBEEF, 32'h200, 4'b1111, 32'hDEADBEEF};
      vecs[4] = '{32'h100, 2'b01, 1'b0, 32'h00007FFF, 32'h100, 4'b0011, 32'h00007FFF};
      foreach (vecs[k]) begin
         @(negedge clk);
         applyStimulus(1'b0, vecs[k].addr, vecs[k].dt, vecs[k].uns, 32'h0);
         @(negedge clk);
         ifA.ReqValid = 1'b0;
         ifA.MemRData = vecs[k].rdata;
         checkCount++;
         if (ifA.MemAddr !== vecs[k].expAddr || ifA.ByteEnable !== vecs[k].expBe || ifA.MemValid !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL load_vec%0d_beat: got ma=%h be=%b mv=%b expected %h %b 1",
                     k, ifA.MemAddr, ifA.ByteEnable, ifA.MemValid, vecs[k].expAddr, vecs[k].expBe);
         end
         @(negedge clk);
         checkCount++;
         if (ifA.RespValid !== 1'b1 || ifA.ReadData !== vecs[k].expData) begin
            errorCount++;
            $display("[TB] FAIL load_vec%0d_data: got rv=%b rd=%h expected 1 %h",
                     k, ifA.RespValid, ifA.ReadData, vecs[k].expData);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_split_store();
      logic [31:0] addrs[2];
      logic [31:0] datas[2];
      logic [31:0] expA0[2];
      logic [31:0] expA1[2];
      logic [31:0] expD0[2];
      logic [31:0] expD1[2];
      addrs = '{32'h000001FE, 32'hFFFFFFFE};
      datas = '{32'h11223344, 32'hA1B2C3D4};
      expA0 = '{32'h000001FC, 32'hFFFFFFFC};
      expA1 = '{32'h00000200, 32'h00000000};
      expD0 = '{32'h33440000, 32'hC3D40000};
      expD1 = '{32'h00001122, 32'h0000A1B2};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         applyStimulus(1'b1, addrs[k], 2'b10, 1'b0, datas[k]);
         @(negedge clk);
         ifA.ReqValid = 1'b0;
         checkCount++;
         if (ifA.MemValid !== 1'b1 || ifA.MemWrite !== 1'b1 || ifA.MemAddr !== expA0[k] ||
             ifA.ByteEnable !== 4'b1100 || ifA.MemWData !== expD0[k]) begin
            errorCount++;
            $display("[TB] FAIL split_store%0d_beat0: got mv=%b mw=%b ma=%h be=%b wd=%h expected 1 1 %h 1100 %h",
                     k, ifA.MemValid, ifA.MemWrite, ifA.MemAddr, ifA.ByteEnable, ifA.MemWData, expA0[k], expD0[k]);
         end
         @(negedge clk);
         checkCount++;
         if (ifA.MemValid !== 1'b1 || ifA.MemAddr !== expA1[k] || ifA.ByteEnable !== 4'b0011 ||
             ifA.MemWData !== expD1[k] || ifA.RespValid !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL split_store%0d_beat1: got mv=%b ma=%h be=%b wd=%h rv=%b expected 1 %h 0011 %h 0",
                     k, ifA.MemValid, ifA.MemAddr, ifA.ByteEnable, ifA.MemWData, ifA.RespValid, expA1[k], expD1[k]);
         end
         @(negedge clk);
         checkCount++;
         if (ifA.RespValid !== 1'b1 || ifA.ReadData !== 32'h0 || ifA.Error !== 1'b0 || ifA.MemValid !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL split_store%0d_resp: got rv=%b rd=%h err=%b mv=%b expected 1 0 0 0",
                     k, ifA.RespValid, ifA.ReadData, ifA.Error, ifA.MemValid);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_split_load();
      @(negedge clk);
      applyStimulus(1'b0, 32'h1FE, 2'b10, 1'b0, 32'h0);
      @(negedge clk);
      ifA.ReqValid = 1'b0;
      ifA.MemRData = 32'hAABBCCDD;
      @(negedge clk);
      ifA.MemRData = 32'h11223344;
      checkCount++;
      if (ifA.RespValid !== 1'b0 || ifA.MemAddr !== 32'h200) begin
         errorCount++;
         $display("[TB] FAIL split_load_latency: got rv=%b ma=%h expected 0 00000200", ifA.RespValid, ifA.MemAddr);
      end
      @(negedge clk);
      checkCount++;
      if (ifA.RespValid !== 1'b1 || ifA.ReadData !== 32'h3344AABB) begin
         errorCount++;
         $display("[TB] FAIL split_load_word: got rv=%b rd=%h expected 1 3344aabb", ifA.RespValid, ifA.ReadData);
      end
      @(negedge clk);
      applyStimulus(1'b0, 32'h103, 2'b01, 1'b0, 32'h0);
      @(negedge clk);
      ifA.ReqValid = 1'b0;
      ifA.MemRData = 32'h85000000;
      checkCount++;
      if (ifA.ByteEnable !== 4'b1000) begin
         errorCount++;
         $display("[TB] FAIL split_half_be0: got %b expected 1000", ifA.ByteEnable);
      end
      @(negedge clk);
      ifA.MemRData = 32'h000000FF;
      checkCount++;
      if (ifA.ByteEnable !== 4'b0001 || ifA.MemAddr !== 32'h104) begin
         errorCount++;
         $display("[TB] FAIL split_half_be1: got be=%b ma=%h expected 0001 00000104", ifA.ByteEnable, ifA.MemAddr);
      end
      @(negedge clk);
      checkCount++;
      if (ifA.RespValid !== 1'b1 || ifA.ReadData !== 32'hFFFFFF85) begin
         errorCount++;
         $display("[TB] FAIL split_half_data: got rv=%b rd=%h expected 1 ffffff85", ifA.RespValid, ifA.ReadData);
      end
      @(negedge clk);
   endtask

   task automatic test_misaligned_error();
      int beatsStart;
      beatsStart = memBeatsB;
      @(negedge clk);
      ifB.ReqValid = 1'b1;
      ifB.ReqWrite = 1'b0;
      ifB.Address  = 32'h001;
      ifB.DataType = 2'b10;
      ifB.Unsigned = 1'b0;
      @(negedge clk);
      ifB.ReqValid = 1'b0;
      checkCount++;
      if (ifB.RespValid !== 1'b1 || ifB.Error !== 1'b1 || ifB.ReadData !== 32'h0 || ifB.MemValid !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL misaligned_resp: got rv=%b err=%b rd=%h mv=%b expected 1 1 0 0",
                  ifB.RespValid, ifB.Error, ifB.ReadData, ifB.MemValid);
      end
      @(negedge clk);
      checkCount++;
      if (ifB.RespValid !== 1'b0 || ifB.Error !== 1'b1 || ifB.ReqReady !== 1'b1 || memBeatsB != beatsStart) begin
         errorCount++;
         $display("[TB] FAIL misaligned_after: got rv=%b err=%b rdy=%b beats=%0d expected 0 1 1 0",
                  ifB.RespValid, ifB.Error, ifB.ReqReady, memBeatsB - beatsStart);
      end
      ifB.ReqValid = 1'b1;
      ifB.Address  = 32'h004;
      @(negedge clk);
      ifB.ReqValid = 1'b0;
      ifB.MemRData = 32'h01020304;
      checkCount++;
      if (ifB.MemValid !== 1'b1 || ifB.MemAddr !== 32'h004 || ifB.ByteEnable !== 4'b1111) begin
         errorCount++;
         $display("[TB] FAIL aligned_B_beat: got mv=%b ma=%h be=%b expected 1 00000004 1111",
                  ifB.MemValid, ifB.MemAddr, ifB.ByteEnable);
      end
      @(negedge clk);
      checkCount++;
      if (ifB.RespValid !== 1'b1 || ifB.Error !== 1'b0 || ifB.ReadData !== 32'h01020304) begin
         errorCount++;
         $display("[TB] FAIL aligned_B_resp: got rv=%b err=%b rd=%h expected 1 0 01020304",
                  ifB.RespValid, ifB.Error, ifB.ReadData);
      end
      @(negedge clk);
   endtask

   task automatic test_stall();
      int respStart;
      respStart = respCountA;
      ifA.MemReady = 1'b0;
      @(negedge clk);
      applyStimulus(1'b1, 32'h306, 2'b01, 1'b0, 32'hBEEF);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         ifA.ReqValid = 1'b0;
         checkCount++;
         if (ifA.MemValid !== 1'b1 || ifA.MemWrite !== 1'b1 || ifA.MemAddr !== 32'h304 ||
             ifA.ByteEnable !== 4'b1100 || ifA.MemWData !== 32'hBEEF0000 || ifA.RespValid !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL stall_hold%0d: got mv=%b mw=%b ma=%h be=%b wd=%h rv=%b expected 1 1 00000304 1100 beef0000 0",
                     k, ifA.MemValid, ifA.MemWrite, ifA.MemAddr, ifA.ByteEnable, ifA.MemWData, ifA.RespValid);
         end
      end
      ifA.MemReady = 1'b1;
      @(negedge clk);
      checkCount++;
      if (ifA.RespValid !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL stall_resp: got %b expected 1", ifA.RespValid);
      end
      repeat (3) @(negedge clk);
      checkCount++;
      if (respCountA - respStart != 1) begin
         errorCount++;
         $display("[TB] FAIL stall_resp_count: got %0d expected 1", respCountA - respStart);
      end
   endtask

   task automatic test_reset_mid_access();
      int respStart;
      @(negedge clk);
      applyStimulus(1'b1, 32'h1FE, 2'b10, 1'b0, 32'h11223344);
      @(negedge clk);
      ifA.ReqValid = 1'b0;
      @(negedge clk);
      checkCount++;
      if (ifA.MemAddr !== 32'h200 || ifA.MemValid !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL reset_mid_beat1: got ma=%h mv=%b expected 00000200 1", ifA.MemAddr, ifA.MemValid);
      end
      respStart = respCountA;
      #2 rst_n = 1'b0;
      #1;
      checkCount++;
      if (ifA.MemValid !== 1'b0 || ifA.ByteEnable !== 4'h0 || ifA.MemWrite !== 1'b0 || ifA.MemAddr !== 32'h0 ||
          ifA.MemWData !== 32'h0 || ifA.RespValid !== 1'b0 || ifA.ReqReady !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL reset_mid_outputs: got mv=%b be=%b mw=%b ma=%h wd=%h rv=%b rdy=%b expected 0 0 0 0 0 0 1",
                  ifA.MemValid, ifA.ByteEnable, ifA.MemWrite, ifA.MemAddr, ifA.MemWData, ifA.RespValid, ifA.ReqReady);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkCount++;
      if (respCountA != respStart || ifA.ReqReady !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL reset_mid_no_resp: got resp=%0d rdy=%b expected 0 1", respCountA - respStart, ifA.ReqReady);
      end
      applyStimulus(1'b0, 32'h102, 2'b01, 1'b0, 32'h0);
      @(negedge clk);
      ifA.ReqValid = 1'b0;
      ifA.MemRData = 32'h80015555;
      @(negedge clk);
      checkCount++;
      if (ifA.RespValid !== 1'b1 || ifA.ReadData !== 32'hFFFF8001) begin
         errorCount++;
         $display("[TB] FAIL reset_mid_new_req: got rv=%b rd=%h expected 1 ffff8001", ifA.RespValid, ifA.ReadData);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      applyStimulus(1'b1, 32'h103, 2'b00, 1'b0, 32'hAB);
      @(negedge clk);
      applyStimulus(1'b0, 32'h100, 2'b00, 1'b1, 32'h0);
      checkCount++;
      if (ifA.ReqReady !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL b2b_busy: got rdy=%b expected 0", ifA.ReqReady);
      end
      @(negedge clk);
      checkCount++;
      if (ifA.RespValid !== 1'b1 || ifA.ReqReady !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL b2b_resp_no_accept: got rv=%b rdy=%b expected 1 0", ifA.RespValid, ifA.ReqReady);
      end
      @(negedge clk);
      ifA.MemRData = 32'h000000C3;
      checkCount++;
      if (ifA.ReqReady !== 1'b1 || ifA.MemValid !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL b2b_idle: got rdy=%b mv=%b expected 1 0", ifA.ReqReady, ifA.MemValid);
      end
      @(negedge clk);
      ifA.ReqValid = 1'b0;
      checkCount++;
      if (ifA.MemValid !== 1'b1 || ifA.MemWrite !== 1'b0 || ifA.ByteEnable !== 4'b0001) begin
         errorCount++;
         $display("[TB] FAIL b2b_second_beat: got mv=%b mw=%b be=%b expected 1 0 0001",
                  ifA.MemValid, ifA.MemWrite, ifA.ByteEnable);
      end
      @(negedge clk);
      checkCount++;
      if (ifA.RespValid !== 1'b1 || ifA.ReadData !== 32'h000000C3) begin
         errorCount++;
         $display("[TB] FAIL b2b_second_data: got rv=%b rd=%h expected 1 000000c3", ifA.RespValid, ifA.ReadData);
      end
      @(negedge clk);
   endtask

   initial begin
      ifA.ReqValid = 1'b0; ifA.ReqWrite = 1'b0; ifA.Address = '0; ifA.DataType = '0;
      ifA.Unsigned = 1'b0; ifA.WriteData = '0; ifA.MemReady = 1'b1; ifA.MemRData = '0;
      ifB.ReqValid = 1'b0; ifB.ReqWrite = 1'b0; ifB.Address = '0; ifB.DataType = '0;
      ifB.Unsigned = 1'b0; ifB.WriteData = '0; ifB.MemReady = 1'b1; ifB.MemRData = '0;
      test_reset();
      test_store_byte();
      test_load_half();
      test_load_extend();
      test_split_store();
      test_split_load();
      test_misaligned_error();
      test_stall();
      test_reset_mid_access();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation did not complete");
   end
endmodule
